// File: rtl/dfi_phy_responder.sv
// PHY-side DFI stand-in: init handshake, fixed-latency read return, ctrlupd ack and periodic phyupd.
// Read valid/data follow a sampled rddata_en by RDLAT cycles; no backpressure, one burst accepted per cycle.
module dfi_phy_responder #(
  parameter int DATA_W        = 128,
  parameter int RDLAT         = 8,
  parameter int INIT_CYCLES   = 64,
  parameter int CTRLUPD_DLY   = 4,
  parameter int PHYUPD_PERIOD = 1024
) (
  input  logic                dfi_clk,
  input  logic                reset_n,
  input  logic                dfi_reset_n_p0,
  input  logic                dfi_init_start,
  output logic                dfi_init_complete,
  input  logic [3:0]          dfi_rddata_en,
  output logic [4*DATA_W-1:0] dfi_rddata,
  output logic [3:0]          dfi_rddata_valid,
  input  logic                dfi_ctrlupd_req,
  output logic                dfi_ctrlupd_ack,
  output logic                dfi_phyupd_req,
  output logic [1:0]          dfi_phyupd_type,
  input  logic                dfi_phyupd_ack,
  output logic                rd_err
);

  localparam int TW     = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int CW     = (CTRLUPD_DLY > 1) ? $clog2(CTRLUPD_DLY) : 1;
  localparam int PW     = (PHYUPD_PERIOD > 1) ? $clog2(PHYUPD_PERIOD) : 1;
  localparam int PER_M1 = (PHYUPD_PERIOD > 0) ? PHYUPD_PERIOD - 1 : 0;

  localparam logic [TW-1:0] TRAIN_LAST = TW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] CTL_LAST   = CW'(CTRLUPD_DLY - 1);
  localparam logic [PW-1:0] PER_LAST   = PW'(PER_M1);

  typedef enum logic [1:0] {ST_RST, ST_WAIT, ST_TRAIN, ST_DONE} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   train_cnt, train_cnt_nxt;
  logic            complete_nxt;

  logic [3:0]          rd_pipe [RDLAT];
  logic [3:0]          rd_accept;
  logic [3:0]          pipe_out;
  logic [7:0]          base;
  logic [7:0]          word_byte;
  logic [4*DATA_W-1:0] rddata_nxt;

  logic            upd_en;
  logic [CW-1:0]   ctl_cnt, ctl_cnt_nxt;
  logic            ctl_ack_nxt;
  logic [PW-1:0]   phy_cnt, phy_cnt_nxt;
  logic            phy_pend, phy_pend_nxt;
  logic            phy_req_nxt;

  assign dfi_phyupd_type = 2'b00;

  // ---------------- init FSM ----------------
  always_ff @(posedge dfi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_RST;
      train_cnt         <= '0;
      dfi_init_complete <= 1'b0;
    end else begin
      state             <= state_nxt;
      train_cnt         <= train_cnt_nxt;
      dfi_init_complete <= complete_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    train_cnt_nxt = train_cnt;
    if (!dfi_reset_n_p0) begin
      state_nxt     = ST_RST;
      train_cnt_nxt = '0;
    end else begin
      case (state)
        ST_RST:   state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (dfi_init_start) begin
            state_nxt     = ST_TRAIN;
            train_cnt_nxt = '0;
          end
        end
        ST_TRAIN: begin
          if (!dfi_init_start) begin
            state_nxt     = ST_WAIT;
            train_cnt_nxt = '0;
          end else if (train_cnt == TRAIN_LAST) begin
            state_nxt     = ST_DONE;
            train_cnt_nxt = '0;
          end else begin
            train_cnt_nxt = train_cnt + 1'b1;
          end
        end
        ST_DONE:  state_nxt = ST_DONE;
        default:  state_nxt = ST_RST;
      endcase
    end
    // complete is a registered view of DONE, dropped on the same edge the DRAM reset is seen
    complete_nxt = (state == ST_DONE) && dfi_reset_n_p0;
  end

  // ---------------- read path ----------------
  assign rd_accept = dfi_rddata_en & {4{dfi_init_complete}};
  assign pipe_out  = rd_pipe[RDLAT-1];

  always_comb begin
    rddata_nxt = '0;
    word_byte  = '0;
    for (int i = 0; i < 4; i++) begin
      word_byte = base + 8'(i);
      if (pipe_out[i]) rddata_nxt[i*DATA_W +: DATA_W] = {(DATA_W/8){word_byte}};
    end
  end

  always_ff @(posedge dfi_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RDLAT; i++) rd_pipe[i] <= '0;
      dfi_rddata_valid <= '0;
      dfi_rddata       <= '0;
      base             <= '0;
      rd_err           <= 1'b0;
    end else begin
      if ((|dfi_rddata_en) && !dfi_init_complete) rd_err <= 1'b1;
      if (!dfi_reset_n_p0) begin
        for (int i = 0; i < RDLAT; i++) rd_pipe[i] <= '0;
        dfi_rddata_valid <= '0;
        dfi_rddata       <= '0;
      end else begin
        rd_pipe[0] <= rd_accept;
        for (int i = 1; i < RDLAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        dfi_rddata_valid <= pipe_out;
        dfi_rddata       <= rddata_nxt;
        if (|pipe_out) base <= base + 8'd4;
      end
    end
  end

  // ---------------- ctrlupd / phyupd ----------------
  assign upd_en = dfi_init_complete && dfi_reset_n_p0;

  always_comb begin
    ctl_cnt_nxt = ctl_cnt;
    ctl_ack_nxt = dfi_ctrlupd_ack;
    if (!upd_en || !dfi_ctrlupd_req) begin
      ctl_cnt_nxt = '0;
      ctl_ack_nxt = 1'b0;
    end else if (!dfi_ctrlupd_ack) begin
      // a ready ack waits out an outstanding phyupd so the two never overlap
      if (ctl_cnt == CTL_LAST) begin
        if (!dfi_phyupd_req) ctl_ack_nxt = 1'b1;
      end else begin
        ctl_cnt_nxt = ctl_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    phy_cnt_nxt  = phy_cnt;
    phy_pend_nxt = phy_pend;
    phy_req_nxt  = dfi_phyupd_req;
    if (!upd_en || (PHYUPD_PERIOD == 0)) begin
      phy_cnt_nxt  = '0;
      phy_pend_nxt = 1'b0;
      phy_req_nxt  = 1'b0;
    end else begin
      if (dfi_phyupd_req) begin
        if (dfi_phyupd_ack) phy_req_nxt = 1'b0;
      end else if (!phy_pend) begin
        if (phy_cnt == PER_LAST) begin
          phy_cnt_nxt  = '0;
          phy_pend_nxt = 1'b1;
        end else begin
          phy_cnt_nxt = phy_cnt + 1'b1;
        end
      end
      if (phy_pend_nxt && !ctl_ack_nxt) begin
        phy_req_nxt  = 1'b1;
        phy_pend_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge dfi_clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_cnt         <= '0;
      dfi_ctrlupd_ack <= 1'b0;
      phy_cnt         <= '0;
      phy_pend        <= 1'b0;
      dfi_phyupd_req  <= 1'b0;
    end else begin
      ctl_cnt         <= ctl_cnt_nxt;
      dfi_ctrlupd_ack <= ctl_ack_nxt;
      phy_cnt         <= phy_cnt_nxt;
      phy_pend        <= phy_pend_nxt;
      dfi_phyupd_req  <= phy_req_nxt;
    end
  end

endmodule

// File: tb/tb_dfi_phy_responder.sv
// Bench for dfi_phy_responder: init timing, read table, randomized read stream vs queue model, update handshakes.
module tb_dfi_phy_responder;

  localparam int DATA_W        = 128;
  localparam int RDLAT         = 8;
  localparam int INIT_CYCLES   = 64;
  localparam int CTRLUPD_DLY   = 4;
  localparam int PHYUPD_PERIOD = 1024;
  localparam int BUS_W         = 4 * DATA_W;

  logic             dfi_clk = 1'b0;
  logic             reset_n;
  logic             dfi_reset_n_p0;
  logic             dfi_init_start;
  logic             dfi_init_complete;
  logic [3:0]       dfi_rddata_en;
  logic [BUS_W-1:0] dfi_rddata;
  logic [3:0]       dfi_rddata_valid;
  logic             dfi_ctrlupd_req;
  logic             dfi_ctrlupd_ack;
  logic             dfi_phyupd_req;
  logic [1:0]       dfi_phyupd_type;
  logic             dfi_phyupd_ack;
  logic             rd_err;

  always #5 dfi_clk = ~dfi_clk;

  dfi_phy_responder #(
    .DATA_W(DATA_W), .RDLAT(RDLAT), .INIT_CYCLES(INIT_CYCLES),
    .CTRLUPD_DLY(CTRLUPD_DLY), .PHYUPD_PERIOD(PHYUPD_PERIOD)
  ) dut (
    .dfi_clk(dfi_clk), .reset_n(reset_n), .dfi_reset_n_p0(dfi_reset_n_p0),
    .dfi_init_start(dfi_init_start), .dfi_init_complete(dfi_init_complete),
    .dfi_rddata_en(dfi_rddata_en), .dfi_rddata(dfi_rddata), .dfi_rddata_valid(dfi_rddata_valid),
    .dfi_ctrlupd_req(dfi_ctrlupd_req), .dfi_ctrlupd_ack(dfi_ctrlupd_ack),
    .dfi_phyupd_req(dfi_phyupd_req), .dfi_phyupd_type(dfi_phyupd_type),
    .dfi_phyupd_ack(dfi_phyupd_ack), .rd_err(rd_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_no = 0;

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  exp_vld;
    logic [31:0] exp_b;   // expected byte per word, word0 in bits 7:0
  } rd_vec_t;

  typedef struct {
    int         at;
    logic [3:0] en;
  } pend_t;

  rd_vec_t    tbl [7];
  pend_t      q [$];
  logic [7:0] mbase;

  task automatic tick();
    @(posedge dfi_clk);
    #1;
    edge_no++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h want %0h", name, edge_no, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h want %0h", name, edge_no, act, exp);
    end
  endtask

  // every byte of word i equals b[i]; unflagged words are zero
  function automatic logic [BUS_W-1:0] mk_bus(input logic [3:0] v, input logic [31:0] b);
    logic [BUS_W-1:0] d;
    logic [7:0]       by;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      by = b[i*8 +: 8];
      if (v[i]) d[i*DATA_W +: DATA_W] = {(DATA_W/8){by}};
    end
    return d;
  endfunction

  // one read-stream cycle against the queue model
  task automatic rd_cycle(input logic [3:0] en);
    logic [3:0]  exp_v;
    logic [31:0] bytes;
    pend_t       p;
    dfi_rddata_en = en;
    tick();
    if (en != 4'h0) q.push_back('{edge_no + RDLAT, en});
    exp_v = 4'h0;
    if (q.size() > 0 && q[0].at == edge_no) begin
      p = q.pop_front();
      exp_v = p.en;
    end
    bytes = {mbase + 8'd3, mbase + 8'd2, mbase + 8'd1, mbase};
    chk("stream_vld", 32'(dfi_rddata_valid), 32'(exp_v));
    chk_bus("stream_dat", dfi_rddata, mk_bus(exp_v, bytes));
    if (exp_v != 4'h0) mbase = mbase + 8'd4;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s_edge, r_edge, c_edge, b_edge;
    logic [3:0] r;

    tbl[0] = '{4'hF, 4'hF, 32'h03020100};
    tbl[1] = '{4'hF, 4'hF, 32'h07060504};
    tbl[2] = '{4'h5, 4'h5, 32'h000A0008};
    tbl[3] = '{4'hA, 4'hA, 32'h0F000D00};
    tbl[4] = '{4'h0, 4'h0, 32'h00000000};
    tbl[5] = '{4'h8, 4'h8, 32'h13000000};
    tbl[6] = '{4'h1, 4'h1, 32'h00000014};

    reset_n = 1'b0; dfi_reset_n_p0 = 1'b0; dfi_init_start = 1'b0;
    dfi_rddata_en = 4'h0; dfi_ctrlupd_req = 1'b0; dfi_phyupd_ack = 1'b0;
    repeat (3) tick();
    chk("rst_complete", 32'(dfi_init_complete), 0);
    chk("rst_valid", 32'(dfi_rddata_valid), 0);
    chk_bus("rst_data", dfi_rddata, '0);
    chk("rst_ctl_ack", 32'(dfi_ctrlupd_ack), 0);
    chk("rst_phy_req", 32'(dfi_phyupd_req), 0);
    chk("rst_phy_type", 32'(dfi_phyupd_type), 0);
    chk("rst_rd_err", 32'(rd_err), 0);
    reset_n = 1'b1;
    tick();
    dfi_reset_n_p0 = 1'b1;
    tick();

    // read enable before init: dropped, error flagged
    dfi_rddata_en = 4'hF;
    tick();
    dfi_rddata_en = 4'h0;
    chk("early_rd_err", 32'(rd_err), 1);
    for (int k = 0; k < RDLAT + 2; k++) begin
      tick();
      chk("early_no_vld", 32'(dfi_rddata_valid), 0);
    end

    // init aborted after 20 training cycles, then restarted
    dfi_init_start = 1'b1;
    tick();
    s_edge = edge_no;
    while (edge_no < s_edge + 20) tick();
    dfi_init_start = 1'b0;
    tick();
    chk("abort_complete", 32'(dfi_init_complete), 0);
    tick();
    dfi_init_start = 1'b1;
    tick();
    r_edge = edge_no;
    c_edge = r_edge + INIT_CYCLES + 1;
    for (int k = 1; k <= INIT_CYCLES + 2; k++) begin
      tick();
      chk("restart_complete", 32'(dfi_init_complete), (k >= INIT_CYCLES + 1) ? 1 : 0);
    end
    dfi_init_start = 1'b0;

    // single-burst read table
    for (int k = 0; k < 7; k++) begin
      dfi_rddata_en = tbl[k].en;
      tick();
      dfi_rddata_en = 4'h0;
      repeat (RDLAT - 1) tick();
      chk("tbl_early", 32'(dfi_rddata_valid), 0);
      tick();
      chk("tbl_vld", 32'(dfi_rddata_valid), 32'(tbl[k].exp_vld));
      chk_bus("tbl_dat", dfi_rddata, mk_bus(tbl[k].exp_vld, tbl[k].exp_b));
      tick();
      chk("tbl_clear", 32'(dfi_rddata_valid), 0);
    end

    // streaming then randomized reads against the queue model
    mbase = 8'd24;
    for (int k = 0; k < 16; k++) rd_cycle(4'h5);
    for (int k = 0; k < 200; k++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'h0;
      rd_cycle(r);
    end
    for (int k = 0; k < RDLAT + 2; k++) rd_cycle(4'h0);
    chk("model_drained", 32'(q.size()), 0);

    // ctrlupd: ack after CTRLUPD_DLY samples, drops after req low
    dfi_ctrlupd_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("ctl_ack_rise", 32'(dfi_ctrlupd_ack), (k >= CTRLUPD_DLY) ? 1 : 0);
    end
    dfi_ctrlupd_req = 1'b0;
    tick();
    chk("ctl_ack_drop", 32'(dfi_ctrlupd_ack), 0);
    dfi_ctrlupd_req = 1'b1;
    repeat (2) tick();
    dfi_ctrlupd_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ctl_short_req", 32'(dfi_ctrlupd_ack), 0);
    end

    // phyupd falls due while ctrlupd_ack is high: deferred
    while (edge_no < c_edge + PHYUPD_PERIOD - 8) tick();
    dfi_ctrlupd_req = 1'b1;
    while (edge_no < c_edge + PHYUPD_PERIOD + 6) begin
      tick();
      chk("defer_phy_low", 32'(dfi_phyupd_req), 0);
      chk("defer_ctl_ack", 32'(dfi_ctrlupd_ack), (edge_no >= c_edge + PHYUPD_PERIOD - 4) ? 1 : 0);
    end
    dfi_ctrlupd_req = 1'b0;
    tick();
    chk("handover_ctl", 32'(dfi_ctrlupd_ack), 0);
    chk("handover_phy", 32'(dfi_phyupd_req), 1);
    chk("phy_type", 32'(dfi_phyupd_type), 0);

    // ctrlupd during phyupd: no ack until phyupd is acked
    dfi_ctrlupd_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("phy_hold", 32'(dfi_phyupd_req), 1);
      chk("ctl_blocked", 32'(dfi_ctrlupd_ack), 0);
    end
    dfi_phyupd_ack = 1'b1;
    tick();
    b_edge = edge_no;
    dfi_phyupd_ack = 1'b0;
    chk("phy_acked", 32'(dfi_phyupd_req), 0);
    chk("ctl_still_low", 32'(dfi_ctrlupd_ack), 0);
    tick();
    chk("ctl_after_phy", 32'(dfi_ctrlupd_ack), 1);
    chk("phy_after_ack", 32'(dfi_phyupd_req), 0);
    dfi_ctrlupd_req = 1'b0;

    // next period counted from the phyupd ack
    while (edge_no < b_edge + PHYUPD_PERIOD - 1) tick();
    chk("phy_period_early", 32'(dfi_phyupd_req), 0);
    tick();
    chk("phy_period_due", 32'(dfi_phyupd_req), 1);
    dfi_phyupd_ack = 1'b1;
    tick();
    dfi_phyupd_ack = 1'b0;
    chk("phy_period_acked", 32'(dfi_phyupd_req), 0);

    // DRAM reset mid-read flushes everything
    dfi_rddata_en = 4'hF;
    tick();
    dfi_rddata_en = 4'h0;
    repeat (3) tick();
    dfi_reset_n_p0 = 1'b0;
    tick();
    chk("p0_complete", 32'(dfi_init_complete), 0);
    for (int k = 0; k < RDLAT + 2; k++) begin
      tick();
      chk("p0_no_vld", 32'(dfi_rddata_valid), 0);
    end
    chk_bus("p0_no_data", dfi_rddata, '0);

    // full init from clean WAIT: complete INIT_CYCLES+1 edges after init_start sampled
    dfi_reset_n_p0 = 1'b1;
    tick();
    repeat (8) tick();
    dfi_init_start = 1'b1;
    tick();
    for (int k = 1; k <= INIT_CYCLES + 2; k++) begin
      tick();
      if (k >= INIT_CYCLES - 2)
        chk("init_complete", 32'(dfi_init_complete), (k >= INIT_CYCLES + 1) ? 1 : 0);
    end
    dfi_init_start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
